// File: rtl/dff_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dff_ram_pkg
// Description : Shared types and default sizes for the two-requester DFF RAM
//               arbiter slice (state encoding, requester identifiers).
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package dff_ram_pkg;

    localparam int c_ADDR_W_DEFAULT = 2;
    localparam int c_DATA_W_DEFAULT = 72;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    typedef enum logic [0:0] {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

endpackage : dff_ram_pkg
`default_nettype wire

// File: rtl/dff_ram.sv
`default_nettype none
// ============================================================================
// Module      : dff_ram
// Description : Single-port flop-based RAM with registered read data. A read
//               command returns data on rdata the cycle after it is presented.
//               Contents are not reset; the arbiter clears them after reset.
// Ports       : clk               - clock
//               enb, wr           - enable, write select (1 = write)
//               addr, wdata       - address, write data
//               rdata             - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module dff_ram
    import dff_ram_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W_DEFAULT,
    parameter int DATA_W = c_DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              enb,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int c_DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [c_DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (enb) begin
            if (wr) begin
                r_mem[addr] <= wdata;
            end else begin
                r_rdata <= r_mem[addr];
            end
        end
    end

    assign rdata = r_rdata;

endmodule : dff_ram
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter. Grant is combinational from the
//               request vector; the tie-break priority flips to the other
//               requester whenever a grant is consumed (advance=1).
// Ports       : clk, rst          - clock, synchronous active-high reset
//               req[1:0]          - request vector (bit0 = A, bit1 = B)
//               advance           - the current grant was accepted
//               gnt[1:0]          - one-hot grant (zero when no request)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // 1 means B wins the next tie; after reset A has priority.
    logic r_prio_b;

    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = r_prio_b ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio_b <= 1'b0;
        end else if (advance && (gnt != 2'b00)) begin
            // Whoever was just served loses the next tie.
            r_prio_b <= gnt[0];
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/dff_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dff_ram_arbiter
// Description : Shares one single-port DFF RAM between requesters A and B.
//               After reset the RAM is swept to zero; then commands are
//               arbitrated round-robin and re-registered onto the RAM pins.
//               Read data returns to the issuer two cycles after acceptance.
// Ports       : clk, rst                         - clock, sync active-high reset
//               a_req_valid/ready/wr/addr/data   - requester A command
//               a_rsp_valid                      - A read-result strobe
//               b_req_valid/ready/wr/addr/data   - requester B command
//               b_rsp_valid                      - B read-result strobe
//               rsp_data                         - shared read data (ram_rdata)
//               init_done                        - clear sweep complete
//               ram_enb/wr/addr/wdata            - registered RAM command
//               ram_rdata                        - RAM registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module dff_ram_arbiter
    import dff_ram_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W_DEFAULT,
    parameter int DATA_W = c_DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              a_req_valid,
    output logic              a_req_ready,
    input  logic              a_req_wr,
    input  logic [ADDR_W-1:0] a_req_addr,
    input  logic [DATA_W-1:0] a_req_data,
    output logic              a_rsp_valid,

    input  logic              b_req_valid,
    output logic              b_req_ready,
    input  logic              b_req_wr,
    input  logic [ADDR_W-1:0] b_req_addr,
    input  logic [DATA_W-1:0] b_req_data,
    output logic              b_rsp_valid,

    output logic [DATA_W-1:0] rsp_data,
    output logic              init_done,

    output logic              ram_enb,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int              c_DEPTH    = 2 ** ADDR_W;
    localparam logic [0:0]      c_ST_CLEAR = 1'(CLEAR);
    localparam logic [0:0]      c_ST_RUN   = 1'(RUN);
    localparam logic [ADDR_W:0] c_CLR_LAST = (ADDR_W + 1)'(c_DEPTH - 1);

    logic [0:0]        r_state;
    logic [ADDR_W:0]   r_clr_cnt;
    logic              r_init_done;

    logic              r_ram_enb;
    logic              r_ram_wr;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;

    // In-flight read tracking: stage 1 lines up with the RAM command,
    // stage 2 with the registered RAM read data.
    logic              r_s1_v;
    req_id_t           r_s1_id;
    logic              r_s2_v;
    req_id_t           r_s2_id;

    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    logic              w_acc;
    logic              w_sel_b;
    logic              w_acc_wr;
    logic [ADDR_W-1:0] w_acc_addr;
    logic [DATA_W-1:0] w_acc_data;

    // No requests reach the arbiter until the sweep is done, so neither
    // ready can rise and the pointer cannot move during CLEAR.
    assign w_req = {b_req_valid, a_req_valid} & {2{r_init_done}};

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (w_req),
        .advance (w_acc),
        .gnt     (w_gnt)
    );

    // A grant implies a valid request, so any grant is an accept.
    assign w_acc       = |w_gnt;
    assign w_sel_b     = w_gnt[1];
    assign a_req_ready = w_gnt[0];
    assign b_req_ready = w_gnt[1];

    assign w_acc_wr   = w_sel_b ? b_req_wr   : a_req_wr;
    assign w_acc_addr = w_sel_b ? b_req_addr : a_req_addr;
    assign w_acc_data = w_sel_b ? b_req_data : a_req_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_CLEAR;
            r_clr_cnt   <= '0;
            r_init_done <= 1'b0;
            r_ram_enb   <= 1'b0;
            r_ram_wr    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_s1_v      <= 1'b0;
            r_s1_id     <= REQ_A;
            r_s2_v      <= 1'b0;
            r_s2_id     <= REQ_A;
        end else begin
            r_s1_v  <= w_acc & ~w_acc_wr;
            r_s1_id <= w_sel_b ? REQ_B : REQ_A;
            r_s2_v  <= r_s1_v;
            r_s2_id <= r_s1_id;

            // init_done trails the CLEAR->RUN transition by one cycle so the
            // last sweep write is on the pins before any requester is served.
            if (r_state == c_ST_RUN) begin
                r_init_done <= 1'b1;
            end

            case (r_state)
                c_ST_CLEAR: begin
                    r_ram_enb   <= 1'b1;
                    r_ram_wr    <= 1'b1;
                    r_ram_addr  <= r_clr_cnt[ADDR_W-1:0];
                    r_ram_wdata <= '0;
                    r_clr_cnt   <= r_clr_cnt + 1'b1;
                    if (r_clr_cnt == c_CLR_LAST) begin
                        r_state <= c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    // Idle cycles drop enable but keep the last command fields.
                    r_ram_enb <= w_acc;
                    if (w_acc) begin
                        r_ram_wr    <= w_acc_wr;
                        r_ram_addr  <= w_acc_addr;
                        r_ram_wdata <= w_acc_data;
                    end
                end
                default: begin
                    r_state <= c_ST_CLEAR;
                end
            endcase
        end
    end

    assign init_done   = r_init_done;
    assign ram_enb     = r_ram_enb;
    assign ram_wr      = r_ram_wr;
    assign ram_addr    = r_ram_addr;
    assign ram_wdata   = r_ram_wdata;
    assign a_rsp_valid = r_s2_v & (r_s2_id == REQ_A);
    assign b_rsp_valid = r_s2_v & (r_s2_id == REQ_B);
    assign rsp_data    = ram_rdata;

endmodule : dff_ram_arbiter
`default_nettype wire

// File: tb/tb_dff_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dff_ram_arbiter
// Description : Self-checking bench for dff_ram_arbiter with dff_ram as the
//               memory. Directed table rows walk the main scenarios (clear
//               sweep, reads, write-then-read, contention, streaming reads,
//               reset with a read in flight), then randomized traffic with
//               occasional resets runs against a transaction-level model
//               (memory array + queue of expected responses keyed by cycle).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dff_ram_arbiter;
    import dff_ram_pkg::*;

    localparam int AW    = 2;
    localparam int DW    = 72;
    localparam int DEPTH = 2 ** AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          a_req_valid, a_req_ready, a_req_wr, a_rsp_valid;
    logic [AW-1:0] a_req_addr;
    logic [DW-1:0] a_req_data;
    logic          b_req_valid, b_req_ready, b_req_wr, b_rsp_valid;
    logic [AW-1:0] b_req_addr;
    logic [DW-1:0] b_req_data;
    logic [DW-1:0] rsp_data;
    logic          init_done;
    logic          ram_enb, ram_wr;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;

    dff_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .a_req_valid (a_req_valid),
        .a_req_ready (a_req_ready),
        .a_req_wr    (a_req_wr),
        .a_req_addr  (a_req_addr),
        .a_req_data  (a_req_data),
        .a_rsp_valid (a_rsp_valid),
        .b_req_valid (b_req_valid),
        .b_req_ready (b_req_ready),
        .b_req_wr    (b_req_wr),
        .b_req_addr  (b_req_addr),
        .b_req_data  (b_req_data),
        .b_rsp_valid (b_rsp_valid),
        .rsp_data    (rsp_data),
        .init_done   (init_done),
        .ram_enb     (ram_enb),
        .ram_wr      (ram_wr),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    dff_ram #(.ADDR_W(AW), .DATA_W(DW)) u_ram (
        .clk   (clk),
        .enb   (ram_enb),
        .wr    (ram_wr),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          rst;
        logic          av, aw;
        logic [AW-1:0] aa;
        logic [DW-1:0] ad;
        logic          bv, bw;
        logic [AW-1:0] ba;
        logic [DW-1:0] bd;
        logic          ea, eb;   // expected a/b_req_ready in this cycle
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic av, input logic aw,
                                input int aa, input logic [DW-1:0] ad,
                                input logic bv, input logic bw, input int ba,
                                input logic [DW-1:0] bd,
                                input logic ea, input logic eb);
        vec_t v;
        v.rst = r;  v.av = av; v.aw = aw; v.aa = AW'(aa); v.ad = ad;
        v.bv = bv;  v.bw = bw; v.ba = AW'(ba); v.bd = bd;
        v.ea = ea;  v.eb = eb;
        return v;
    endfunction

    function automatic vec_t idle(input logic r);
        return mk(r, 0, 0, 0, '0, 0, 0, 0, '0, 0, 0);
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int            due;
        logic          is_b;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          exp_q[$];
    logic [DW-1:0] mem_m [DEPTH];
    int            cyc;        // cycles since reset release (0 = first)
    logic          last_b;     // last granted requester was B
    logic          m_enb, m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        cyc     = 0;
        last_b  = 1'b1;   // A wins the first tie
        m_enb   = 1'b0;
        m_wr    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    endtask

    // One clock cycle: check at the negedge, advance the model, then wait
    // for the next posedge plus a small delay before new inputs are driven.
    task automatic step(input logic use_tbl, input logic ea, input logic eb);
        logic init_e;
        int   g;
        @(negedge clk);
        init_e = (cyc >= DEPTH + 1);
        g = -1;
        if (init_e) begin
            if (a_req_valid && b_req_valid) g = last_b ? 0 : 1;
            else if (a_req_valid)           g = 0;
            else if (b_req_valid)           g = 1;
        end
        chk("init_done", DW'(init_done), DW'(init_e));
        chk("a_req_ready", DW'(a_req_ready), DW'(g == 0));
        chk("b_req_ready", DW'(b_req_ready), DW'(g == 1));
        if (use_tbl) begin
            chk("tbl_a_ready", DW'(a_req_ready), DW'(ea));
            chk("tbl_b_ready", DW'(b_req_ready), DW'(eb));
        end
        chk("ram_enb", DW'(ram_enb), DW'(m_enb));
        chk("ram_wr", DW'(ram_wr), DW'(m_wr));
        chk("ram_addr", DW'(ram_addr), DW'(m_addr));
        chk("ram_wdata", ram_wdata, m_wdata);
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            chk("a_rsp_valid", DW'(a_rsp_valid), DW'(!exp_q[0].is_b));
            chk("b_rsp_valid", DW'(b_rsp_valid), DW'(exp_q[0].is_b));
            chk("rsp_data", rsp_data, exp_q[0].data);
            void'(exp_q.pop_front());
        end else begin
            chk("a_rsp_idle", DW'(a_rsp_valid), '0);
            chk("b_rsp_idle", DW'(b_rsp_valid), '0);
        end

        if (rst) begin
            model_reset();
        end else begin
            if (cyc < DEPTH) begin
                m_enb = 1'b1; m_wr = 1'b1; m_addr = AW'(cyc); m_wdata = '0;
            end else if (g >= 0) begin
                m_enb   = 1'b1;
                m_wr    = (g == 1) ? b_req_wr   : a_req_wr;
                m_addr  = (g == 1) ? b_req_addr : a_req_addr;
                m_wdata = (g == 1) ? b_req_data : a_req_data;
                if (m_wr) mem_m[m_addr] = m_wdata;
                else      exp_q.push_back('{cyc + 2, (g == 1), mem_m[m_addr]});
                last_b = (g == 1);
            end else begin
                m_enb = 1'b0;
            end
            cyc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        rst         = v.rst;
        a_req_valid = v.av; a_req_wr = v.aw; a_req_addr = v.aa; a_req_data = v.ad;
        b_req_valid = v.bv; b_req_wr = v.bw; b_req_addr = v.ba; b_req_data = v.bd;
    endtask

    localparam logic [DW-1:0] D1 = 72'hAB_CDEF_0123_4567_89AB;
    localparam logic [DW-1:0] D2 = 72'h5A_A55A_F00F_1234_5678;

    initial begin
        vec_t v;
        model_reset();
        drive(idle(1'b1));

        // reset, then clear sweep (cycles 0..5)
        repeat (3) tbl.push_back(idle(1'b1));
        repeat (6) tbl.push_back(idle(1'b0));
        // A reads addr 2 after the clear -> zero
        tbl.push_back(mk(0, 1, 0, 2, '0, 0, 0, 0, '0, 1, 0));
        repeat (3) tbl.push_back(idle(1'b0));
        // A writes addr 1, B reads it back the next cycle
        tbl.push_back(mk(0, 1, 1, 1, D1, 0, 0, 0, '0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, '0, 1, 0, 1, '0, 0, 1));
        repeat (3) tbl.push_back(idle(1'b0));
        // contention: both read for 6 cycles, grants alternate starting with A
        for (int i = 0; i < 6; i++)
            tbl.push_back(mk(0, 1, 0, 0, '0, 1, 0, 3, '0, (i % 2) == 0, (i % 2) == 1));
        repeat (3) tbl.push_back(idle(1'b0));
        // B streams reads of every address
        for (int i = 0; i < DEPTH; i++)
            tbl.push_back(mk(0, 0, 0, 0, '0, 1, 0, i, '0, 0, 1));
        repeat (3) tbl.push_back(idle(1'b0));
        // write addr 2, read it, then reset with the read in flight
        tbl.push_back(mk(0, 1, 1, 2, D2, 0, 0, 0, '0, 1, 0));
        tbl.push_back(idle(1'b0));
        tbl.push_back(mk(0, 1, 0, 2, '0, 0, 0, 0, '0, 1, 0));
        tbl.push_back(idle(1'b1));
        repeat (6) tbl.push_back(idle(1'b0));
        // previously written data must be gone after the rerun sweep
        tbl.push_back(mk(0, 1, 0, 2, '0, 0, 0, 0, '0, 1, 0));
        repeat (3) tbl.push_back(idle(1'b0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            step(1'b1, tbl[i].ea, tbl[i].eb);
        end

        // randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            v.rst = ($urandom_range(0, 79) == 0);
            v.av  = $urandom_range(0, 1);
            v.aw  = $urandom_range(0, 1);
            v.aa  = AW'($urandom);
            v.ad  = {8'($urandom), 32'($urandom), 32'($urandom)};
            v.bv  = $urandom_range(0, 1);
            v.bw  = $urandom_range(0, 1);
            v.ba  = AW'($urandom);
            v.bd  = {8'($urandom), 32'($urandom), 32'($urandom)};
            v.ea  = 1'b0;
            v.eb  = 1'b0;
            drive(v);
            step(1'b0, 1'b0, 1'b0);
        end

        // drain any outstanding responses
        drive(idle(1'b0));
        repeat (4) step(1'b0, 1'b0, 1'b0);
        chk("drained", DW'(exp_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule : tb_dff_ram_arbiter
`default_nettype wire

// File: doc/dff_ram_arbiter.md
Name: dff_ram_arbiter

Overview:
Shares one single-port DFF RAM between two requesters, A and B. Each requester uses a valid/ready command handshake and gets a read-response strobe.
- Commands are arbitrated round-robin and re-registered onto the RAM command pins.
- Read data from the RAM returns to the issuing requester two cycles after the command is accepted.
- After every reset the block first sweeps the RAM to zero, so no entry reads as X.

Parameters:
ADDR_W, 2, RAM address width; depth = 2**ADDR_W.
DATA_W, 72, RAM data width.

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  reset, synchronous, active-high.
a_req_valid  in  1  requester A command valid.
a_req_ready  out  1  A command accepted when valid&ready.
a_req_wr  in  1  1=write, 0=read.
a_req_addr  in  ADDR_W  A address.
a_req_data  in  DATA_W  A write data.
a_rsp_valid  out  1  one-cycle strobe: rsp_data holds A's read result.
b_req_valid, b_req_ready, b_req_wr, b_req_addr, b_req_data, b_rsp_valid: same as A, for requester B.
rsp_data  out  DATA_W  shared read data, passthrough of ram_rdata.
init_done  out  1  high once the clear sweep has finished.
ram_enb  out  1  to RAM enable (registered).
ram_wr  out  1  to RAM write select (registered).
ram_addr  out  ADDR_W  to RAM address (registered).
ram_wdata  out  DATA_W  to RAM write data (registered).
ram_rdata  in  DATA_W  from RAM read data; registered in the RAM, valid the cycle after a read command.

Behaviour:
- Reset: synchronous and active-high, sampled on posedge clk. While rst=1, the next edge sets:
  - FSM = CLEAR, clr_cnt=0;
  - ram_enb, ram_wr, ram_addr, ram_wdata = 0;
  - init_done=0, a/b_rsp_valid=0, rr pointer = A.
- Both req_ready outputs are 0 whenever init_done=0.
- Cycle numbering: cycle 0 is the first cycle with rst=0.
- FSM states: CLEAR and RUN.
- CLEAR:
  - Cycles 1..2**ADDR_W present ram_enb=1, ram_wr=1, ram_addr=clr_cnt (0,1,...,max), ram_wdata=0.
  - On the edge that issues addr=max, go to RUN.
  - init_done=1 from cycle 2**ADDR_W+1 (cycle 5 at default) and stays 1 until reset.
- RUN:
  - Each cycle, at most one command is granted.
  - Only A valid -> grant A. Only B valid -> grant B.
  - Both valid -> grant the requester not granted last; the pointer flips on every accepted command.
  - Only the winner's req_ready is 1. req_ready may depend combinationally on the valids.
  - Accept in cycle N (valid&ready): cycle N+1 shows ram_enb=1, ram_wr=req_wr, ram_addr, ram_wdata=req_data.
  - Read accepted in cycle N: the winner's rsp_valid=1 in cycle N+2, and rsp_data=ram_rdata in that cycle.
  - A 2-stage shift of {valid, id} tracks in-flight reads. Writes produce no response.
  - No accept in cycle N -> ram_enb=0 in N+1. ram_addr, ram_wr and ram_wdata hold their previous values.
- Throughput: one command per cycle, sustained. Responses from two reads in consecutive cycles appear in consecutive cycles, in order.
- Ordering: write then read to the same address in adjacent cycles returns the new data. The RAM write completes on the edge before the read is sampled, so no bypass is needed.
- Reset mid-operation:
  - All in-flight read responses are dropped; rsp_valid is 0 from the first edge with rst=1.
  - A command registered onto ram_* in the reset cycle is squashed (ram_enb=0).
  - The clear sweep reruns.
- rsp_data is don't-care whenever both rsp_valid signals are 0.
- A requester may drop valid without being accepted; no command is issued for it.
- Arithmetic: clr_cnt is ADDR_W+1 bits wide to detect the end of the sweep. No other arithmetic.

Decomposition:
- Package dff_ram_pkg holds:
  - ADDR_W and DATA_W defaults;
  - state_t enum {CLEAR, RUN};
  - req_id_t (1 bit, REQ_A=0, REQ_B=1).
- One sub-module, rr_arb2: a 2-way round-robin arbiter.
  - Inputs: req[1:0], advance.
  - Output: one-hot gnt[1:0].
  - The last-grant pointer is held internally and updated on advance.
- FSM, response pipeline and output registers stay in dff_ram_arbiter.
- The bench instantiates dff_ram as the RAM model.

Test Plan:
- Reset released at cycle 0 -> ram_enb=1, ram_wr=1, wdata=0 with addr 0,1,2,3 in cycles 1-4; init_done=1 and readies enabled from cycle 5.
- Post-clear, A reads addr 2 -> a_rsp_valid two cycles after accept, rsp_data=72'h0; b_rsp_valid stays 0.
- A writes 72'hAB_CDEF_0123_4567_89AB to addr 1; next cycle B reads addr 1 -> b_rsp_valid with rsp_data=72'hAB_CDEF_0123_4567_89AB.
- A and B both hold valid reads for 6 cycles, addrs 0 and 3 -> grants alternate A,B,A,B,A,B; responses alternate a/b_rsp_valid with mem[0] and mem[3], one per cycle.
- B issues back-to-back reads of addr 0,1,2,3 -> four consecutive b_rsp_valid cycles with data in address order.
- A read is accepted, then rst=1 the next cycle -> no rsp_valid ever; clear sweep reruns; previously written data reads back 0.
